// File: rtl/secure_init_sequencer_if.sv
// Bus bundle for the secure-init sequencer: mode/warm/start requests in,
// sequenced data word plus status/strobe/done/counter out.
interface secure_init_sequencer_if #(
    parameter int DATA_W     = 32,
    parameter int STROBE_CYC = 14
);
    localparam int CNT_W = $clog2(STROBE_CYC + 1);

    logic              secure_in;
    logic              warm_req;
    logic              start;
    logic [DATA_W-1:0] data_out;
    logic              secure_out;
    logic              status;
    logic              strobe;
    logic              done;
    logic [CNT_W-1:0]  cyc_cnt;

    modport master (
        output secure_in, warm_req, start,
        input  data_out, secure_out, status, strobe, done, cyc_cnt
    );

    modport slave (
        input  secure_in, warm_req, start,
        output data_out, secure_out, status, strobe, done, cyc_cnt
    );
endinterface

// File: rtl/secure_init_sequencer.sv
// Sequences the secure-init datapath after reset: busy flag, strobe, fill.
// Ports: clk, rst (sync active-high), bus (slave): secure_in, warm_req,
// start in; data_out, secure_out, status, strobe, done, cyc_cnt out.
module secure_init_sequencer #(
    parameter int                DATA_W     = 32,
    parameter int                STATUS_CYC = 9,
    parameter int                STROBE_CYC = 14,
    parameter logic [DATA_W-1:0] FILL_VAL   = 'hFF
) (
    input logic                   clk,
    input logic                   rst,
    secure_init_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(STROBE_CYC + 1);
    localparam logic [CNT_W-1:0] C_STATUS = CNT_W'(STATUS_CYC);
    localparam logic [CNT_W-1:0] C_STROBE = CNT_W'(STROBE_CYC);

    typedef enum logic [1:0] {
        S_COUNT,
        S_STROBE,
        S_DONE,
        S_WARM
    } state_t;

    state_t            r_state, w_state;
    state_t            r_ret, w_ret;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [DATA_W-1:0] r_data, w_data;
    logic [DATA_W-1:0] r_shadow, w_shadow;
    logic              r_sec, w_sec;
    logic              r_first, w_first;
    logic              r_status, w_status;
    logic              r_strobe, w_strobe;
    logic              r_done, w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_COUNT;
            r_ret    <= S_COUNT;
            r_cnt    <= '0;
            r_data   <= '0;
            r_shadow <= '0;
            r_sec    <= 1'b0;
            r_first  <= 1'b1;
            r_status <= 1'b1;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ret    <= w_ret;
            r_cnt    <= w_cnt;
            r_data   <= w_data;
            r_shadow <= w_shadow;
            r_sec    <= w_sec;
            r_first  <= w_first;
            r_status <= w_status;
            r_strobe <= w_strobe;
            r_done   <= w_done;
        end
    end

    // Mode seen by this edge's fill: on the sampling edge it is secure_in.
    logic w_sec_eff;

    always_comb begin
        w_state   = r_state;
        w_ret     = r_ret;
        w_cnt     = r_cnt;
        w_data    = r_data;
        w_shadow  = r_shadow;
        w_sec     = r_sec;
        w_first   = r_first;
        w_status  = r_status;
        w_strobe  = r_strobe;
        w_done    = r_done;
        w_sec_eff = r_first ? bus.secure_in : r_sec;

        if (r_state != S_WARM && bus.warm_req) begin
            // Warm entry freezes progress; a strobe in flight ends at DONE.
            w_shadow = r_data;
            w_data   = '0;
            w_strobe = 1'b0;
            w_ret    = (r_state == S_STROBE) ? S_DONE : r_state;
            w_state  = S_WARM;
        end else begin
            unique case (r_state)
                S_COUNT: begin
                    w_cnt = r_cnt + 1'b1;
                    if (r_first) begin
                        w_sec   = bus.secure_in;
                        w_first = 1'b0;
                    end
                    if (w_cnt == C_STATUS) begin
                        w_status = 1'b0;
                        if (!w_sec_eff) w_data = FILL_VAL;
                    end
                    if (w_cnt == C_STROBE) begin
                        w_strobe = 1'b1;
                        if (w_sec_eff) w_data = FILL_VAL;
                        w_state = S_STROBE;
                    end
                end
                S_STROBE: begin
                    w_strobe = 1'b0;
                    w_done   = 1'b1;
                    w_state  = S_DONE;
                end
                S_DONE: begin
                    if (bus.start) begin
                        w_cnt    = '0;
                        w_status = 1'b1;
                        w_done   = 1'b0;
                        w_first  = 1'b1;
                        w_state  = S_COUNT;
                    end
                end
                S_WARM: begin
                    if (!bus.warm_req) begin
                        // Secure contents are never restored after a warm reset.
                        w_data  = r_sec ? '0 : r_shadow;
                        w_state = r_ret;
                        if (r_ret == S_DONE) w_done = 1'b1;
                    end
                end
                default: w_state = S_COUNT;
            endcase
        end
    end

    assign bus.data_out   = r_data;
    assign bus.secure_out = r_sec;
    assign bus.status     = r_status;
    assign bus.strobe     = r_strobe;
    assign bus.done       = r_done;
    assign bus.cyc_cnt    = r_cnt;
endmodule

// File: doc/secure_init_sequencer.md
Name: secure_init_sequencer

Overview:
- Synchronous controller that sequences the secure-init datapath after reset.
- Counts cycles from reset release and drops the `status` (busy) flag at a fixed cycle.
- Issues a one-cycle `strobe`, then fills `data_out` according to the secure mode sampled at start.
- Handles a warm-reset request that blanks `data_out` and then restores or clears it. Sits between the reset/boot logic and the consumers of `data_out`/`strobe`.

Parameters:
- DATA_W, 32, width of `data_out` and the shadow register.
- STATUS_CYC, 9, counter value at which `status` falls and the non-secure fill occurs. Legal: >= 1.
- STROBE_CYC, 14, counter value at which `strobe` pulses and the secure fill occurs. Legal: > STATUS_CYC.
- FILL_VAL, 'hFF, value loaded into `data_out` at fill, zero-extended to DATA_W.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high cold reset.
- secure_in  input  1  secure-mode request, sampled once per sequence.
- warm_req  input  1  level warm-reset request, active-high.
- start  input  1  single-cycle request to re-run the sequence; honoured only in DONE.
- data_out  output  DATA_W  sequenced data word.
- secure_out  output  1  latched secure mode for the current sequence.
- status  output  1  1 = sequence busy, 0 = status phase passed.
- strobe  output  1  one-cycle pulse at STROBE_CYC.
- done  output  1  sequence complete, held until restart or reset.
- cyc_cnt  output  $clog2(STROBE_CYC+1)  current cycle counter.

Behaviour:
- Reset (rst=1 at posedge), all registered:
  - data_out=0, secure_out=0, status=1, strobe=0, done=0, cyc_cnt=0.
  - shadow=0, first=1, state=COUNT.
  - rst has priority over warm_req and start.
- COUNT: cyc_cnt increments by 1 each posedge.
  - On the first posedge after reset release or restart (first=1): secure_out<=secure_in and first<=0. secure_out is then held for the whole sequence.
  - Edge where cyc_cnt becomes STATUS_CYC: status<=0 on that same edge; if secure_out==0, data_out<=FILL_VAL.
  - Edge where cyc_cnt becomes STROBE_CYC: strobe<=1; if secure_out==1, data_out<=FILL_VAL; state<=STROBE.
  - Which secure_out value the fill checks: the one already latched for this sequence. The same-edge sample applies only if STATUS_CYC==1; in that case the fill uses secure_in of that cycle.
- STROBE: next posedge sets strobe<=0 and done<=1; state<=DONE. The strobe is exactly one cycle wide.
- DONE: cyc_cnt saturates at STROBE_CYC; outputs hold.
  - start=1 restarts: cyc_cnt<=0, status<=1, done<=0, first<=1, state<=COUNT. data_out is unchanged until the next fill.
  - start outside DONE is ignored.
- WARM entry: warm_req=1 in any non-WARM state, checked before start and counting.
  - shadow<=data_out, data_out<=0, strobe<=0.
  - ret_state<=current state, or DONE if the current state is STROBE.
  - state<=WARM.
  - cyc_cnt, status, done and secure_out are frozen; no increment on the entry edge.
- WARM: everything is held while warm_req=1.
- WARM exit: first posedge with warm_req=0.
  - data_out<=0 if secure_out==1, else data_out<=shadow.
  - state<=ret_state.
  - If ret_state==DONE (entered from STROBE), done<=1 on the exit edge.
  - Counting resumes on the following edge. A fill or strobe pending at a frozen count fires normally once counting resumes.
- Simultaneous events:
  - warm_req and the STATUS_CYC/STROBE_CYC edge: warm wins; that edge's status/strobe/fill is deferred.
  - warm_req and start in DONE: warm wins; start is dropped.
- Exactly one strobe per sequence. There is no strobe if rst occurs before STROBE_CYC.

Test Plan:
- Non-secure cold boot: rst 1->0, secure_in=0.
  - Required: status=1 through cyc_cnt 8; at cyc_cnt=9 status=0 and data_out=0xFF.
  - Required: strobe=1 only at cyc_cnt=14; done=1 from the next cycle.
- Secure cold boot: secure_in=1 on the first cycle, then toggled 0/1 each cycle.
  - Required: secure_out=1 throughout; data_out=0 until cyc_cnt=14, then 0xFF.
  - Required: status falls at cyc_cnt=9 with no data change.
- Warm in DONE, non-secure: data_out=0xFF, warm_req high for 3 cycles.
  - Required: data_out=0 on the entry edge, then 0xFF on the exit edge; done stays 1; no strobe.
- Warm in DONE, secure: same stimulus as above.
  - Required: data_out=0 on entry and stays 0 after exit.
- Warm at cyc_cnt=13 -> 14 edge, held 4 cycles.
  - Required: cyc_cnt stays 13 and strobe=0 during WARM.
  - Required: strobe fires one edge after exit; single pulse total.
- Restart and reset priority:
  - start in DONE: status returns to 1, cyc_cnt restarts from 0, secure_in re-sampled.
  - rst asserted at cyc_cnt=12 together with warm_req: all outputs at reset values next cycle, no strobe.
